// File: rtl/ckt5.sv
// Positive-edge D register with synchronous active-high reset.
// Parameterised width and reset value so it doubles as a pipeline stage.
module ckt5 #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_p0;

  // Stage 0: the one register; reset dominates the sampled data
  always_ff @(posedge clk) begin
    if (rst) q_p0 <= RESET_VALUE;
    else     q_p0 <= d;
  end

  assign q = q_p0;

endmodule

// File: tb/tb_ckt5.sv
// Bench for ckt5: a 1-bit instance and an 8-bit instance with reset value 8'hA5,
// checked against the "q equals whatever was at the last rising edge" rule.
module tb_ckt5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d   = 1'b0;
  logic       q;
  logic [7:0] d8  = 8'h00;
  logic [7:0] q8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ckt5 u_bit (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  ckt5 #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_byte (
    .clk (clk),
    .rst (rst),
    .d   (d8),
    .q   (q8)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; d = 1'b1; d8 = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL reset_q actual=%b expected=%b", q, 1'b0);
    end
    checks++;
    if (q8 !== 8'hA5) begin
      failures++; $display("FAIL reset_q8 actual=%h expected=%h", q8, 8'hA5);
    end
    @(negedge clk);
    rst = 1'b0; d = 1'b0; d8 = 8'h3C;
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL after_reset_q actual=%b expected=%b", q, 1'b0);
    end
    checks++;
    if (q8 !== 8'h3C) begin
      failures++; $display("FAIL after_reset_q8 actual=%h expected=%h", q8, 8'h3C);
    end
  endtask

  // d high for n edges must give q high for exactly n cycles
  task automatic test_span(input int n);
    @(negedge clk);
    d = 1'b1;
    #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL span_no_early_change n=%0d actual=%b expected=%b", n, q, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        @(posedge clk); #1;
        @(negedge clk); d = 1'b0;
        #1;
        checks++;
        if (q !== 1'b1) begin
          failures++; $display("FAIL span_hold_after_d_fall n=%0d actual=%b expected=%b", n, q, 1'b1);
        end
      end else begin
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
          failures++; $display("FAIL span_high n=%0d cycle=%0d actual=%b expected=%b", n, i, q, 1'b1);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL span_fall n=%0d actual=%b expected=%b", n, q, 1'b0);
    end
  endtask

  task automatic test_short_pulse();
    @(negedge clk); d = 1'b0; d8 = 8'h11;
    @(posedge clk);
    #2 d = 1'b1; d8 = 8'hEE;
    #2 d = 1'b0; d8 = 8'h11;
    #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL short_pulse_mid actual=%b expected=%b", q, 1'b0);
    end
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0) begin
      failures++; $display("FAIL short_pulse_edge actual=%b expected=%b", q, 1'b0);
    end
    checks++;
    if (q8 !== 8'h11) begin
      failures++; $display("FAIL short_pulse_q8 actual=%h expected=%h", q8, 8'h11);
    end
  endtask

  task automatic test_midcycle_reset();
    @(negedge clk); d = 1'b1; d8 = 8'h5A;
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b1) begin
      failures++; $display("FAIL mid_rst_pre actual=%b expected=%b", q, 1'b1);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (q !== 1'b1 || q8 !== 8'h5A) begin
      failures++; $display("FAIL mid_rst_no_async actual=%b/%h expected=%b/%h", q, q8, 1'b1, 8'h5A);
    end
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0 || q8 !== 8'hA5) begin
      failures++; $display("FAIL mid_rst_applied actual=%b/%h expected=%b/%h", q, q8, 1'b0, 8'hA5);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || q8 !== 8'hA5) begin
      failures++; $display("FAIL mid_rst_release_no_async actual=%b/%h expected=%b/%h", q, q8, 1'b0, 8'hA5);
    end
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b1 || q8 !== 8'h5A) begin
      failures++; $display("FAIL mid_rst_recover actual=%b/%h expected=%b/%h", q, q8, 1'b1, 8'h5A);
    end
  endtask

  // Reference: after each edge q is the reset value if rst was high, otherwise d
  task automatic test_random(input int cycles);
    logic       exp_q;
    logic [7:0] exp_q8;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 7) == 0);
      d   = 1'($urandom);
      d8  = 8'($urandom);
      exp_q  = rst ? 1'b0  : d;
      exp_q8 = rst ? 8'hA5 : d8;
      @(posedge clk); #1;
      checks++;
      if (q !== exp_q) begin
        failures++; $display("FAIL random_q cycle=%0d actual=%b expected=%b", i, q, exp_q);
      end
      checks++;
      if (q8 !== exp_q8) begin
        failures++; $display("FAIL random_q8 cycle=%0d actual=%h expected=%h", i, q8, exp_q8);
      end
      // glitch d away from the edge; it must not reach q
      #1 d = ~d; d8 = ~d8;
      #1;
      checks++;
      if (q !== exp_q || q8 !== exp_q8) begin
        failures++; $display("FAIL random_glitch cycle=%0d actual=%b/%h expected=%b/%h", i, q, q8, exp_q, exp_q8);
      end
    end
    @(negedge clk); rst = 1'b0; d = 1'b0; d8 = 8'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_span(1);
    test_span(4);
    test_span($urandom_range(2, 6));
    test_short_pulse();
    test_midcycle_reset();
    test_random(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
